galena_clocked_model: RTL

Clocked, parametrised second-generation behavioural model of the galena analog Ising macro. It contains the weight array, multi-bank spin cache and feedback readout. The model is cycle-deterministic, using programmable settle latency instead of random delays. It adds selectable spin banks, read-valid signalling and sticky protocol-error reporting in place of simulation aborts. It replaces the asynchronous model in digital-macro testbenches, driven by the digital controller's wordline and bitline outputs.

---
 rtl/galena_pkg.sv | 31 +++
 rtl/galena_fb_timer.sv | 78 +++++++
 rtl/galena_clocked_model.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/galena_pkg.sv
// Shared geometry defaults, state/error encodings and spin-slot helper for the
// clocked galena Ising macro model.
package galena_pkg;

   localparam int WWL_WIDTH       = 256;
   localparam int WBL_WIDTH       = 256;
   localparam int NUM_SPIN        = 64;
   localparam int BIT_DATA        = 4;
   localparam int SPIN_WBL_OFFSET = 0;
   localparam int NUM_BANK        = 2;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      VALID  = 2'd2
   } galena_fb_state_e;

   // Lower code means higher priority when several errors hit in one cycle.
   typedef enum logic [1:0] {
      ERR_NONE       = 2'd0,
      ERR_WWL_ONEHOT = 2'd1,
      ERR_WWL_SPIN   = 2'd2,
      ERR_SPIN_BUSY  = 2'd3
   } galena_err_e;

   function automatic logic get_spin(input logic [WBL_WIDTH-1:0] wbl, input int unsigned i);
      return wbl[BIT_DATA*i + SPIN_WBL_OFFSET];
   endfunction

endpackage

// File: rtl/galena_fb_timer.sv
// Feedback sequencer: waits a programmable settle time after a feedback rise,
// then presents the captured bank's spins until feedback is released.
module galena_fb_timer
   import galena_pkg::*;
#(
   parameter int NUM_SPIN = galena_pkg::NUM_SPIN,
   parameter int CNT_W    = galena_pkg::CNT_W,
   parameter int BANK_W   = 1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_fb,
   input  logic                i_fb_rise,
   input  logic [CNT_W-1:0]    i_settle,
   input  logic [BANK_W-1:0]   i_bank,
   input  logic [NUM_SPIN-1:0] i_spins,
   output logic [BANK_W-1:0]   o_bank,
   output logic                o_busy,
   output logic [NUM_SPIN-1:0] o_bct,
   output logic                o_bct_valid
);

   galena_fb_state_e    r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [BANK_W-1:0]   r_bank;
   logic [NUM_SPIN-1:0] r_bct;
   logic                r_bct_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bank      <= '0;
         r_bct       <= '0;
         r_bct_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_fb_rise) begin
                  r_state <= SETTLE;
                  r_bank  <= i_bank;
                  r_cnt   <= (i_settle == '0) ? CNT_W'(1) : i_settle;
               end
            end
            SETTLE: begin
               if (!i_fb) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_W'(1)) begin
                  // Spins are sampled here, so a load that raced the request is seen.
                  r_state     <= VALID;
                  r_cnt       <= '0;
                  r_bct       <= i_spins;
                  r_bct_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            VALID: begin
               if (!i_fb) begin
                  r_state     <= IDLE;
                  r_bct       <= '0;
                  r_bct_valid <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_bank      = r_bank;
   assign o_busy      = (r_state != IDLE);
   assign o_bct       = r_bct;
   assign o_bct_valid = r_bct_valid;

endmodule

// File: rtl/galena_clocked_model.sv
// Cycle-deterministic galena macro model: weight rows, banked spin cache,
// settle-timed feedback readout and sticky first-error reporting.
module galena_clocked_model
   import galena_pkg::*;
#(
   parameter int WWL_WIDTH       = galena_pkg::WWL_WIDTH,
   parameter int WBL_WIDTH       = galena_pkg::WBL_WIDTH,
   parameter int NUM_SPIN        = galena_pkg::NUM_SPIN,
   parameter int BIT_DATA        = galena_pkg::BIT_DATA,
   parameter int SPIN_WBL_OFFSET = galena_pkg::SPIN_WBL_OFFSET,
   parameter int NUM_BANK        = galena_pkg::NUM_BANK,
   parameter int CNT_W           = galena_pkg::CNT_W,
   localparam int BANK_W         = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [WWL_WIDTH-1:0] wwl_i,
   input  logic [WBL_WIDTH-1:0] wbl_i,
   input  logic                 wbl_floating_i,
   input  logic                 write_spin_i,
   input  logic [BANK_W-1:0]    spin_bank_i,
   input  logic                 feedback_i,
   input  logic [CNT_W-1:0]     settle_cycles_i,
   output logic [WBL_WIDTH-1:0] wbl_read_o,
   output logic [WBL_WIDTH-1:0] wblb_read_o,
   output logic                 wbl_read_valid_o,
   output logic [NUM_SPIN-1:0]  bct_read_o,
   output logic                 bct_valid_o,
   output logic                 err_o,
   output logic [1:0]           err_code_o
);

   logic [WWL_WIDTH-1:0] r_wwl_q;
   logic                 r_spin_q;
   logic                 r_fb_q;
   logic [WBL_WIDTH-1:0] r_data [WWL_WIDTH];
   logic [NUM_SPIN-1:0]  r_spin_cache [NUM_BANK];
   logic [WBL_WIDTH-1:0] r_rd_data;
   logic                 r_rd_valid;
   logic                 r_err;
   galena_err_e          r_err_code;

   logic [WBL_WIDTH-1:0] w_rd_data;
   galena_err_e          w_err_code;
   logic                 w_onehot0, w_any_wwl, w_spin_rise, w_fb_rise, w_busy, w_spin_load;
   logic [BANK_W-1:0]    w_bank, w_fb_bank;
   logic [NUM_SPIN-1:0]  w_fb_spins;

   assign w_onehot0   = ((wwl_i & (wwl_i - WWL_WIDTH'(1))) == '0);
   assign w_any_wwl   = |wwl_i;
   assign w_spin_rise = write_spin_i & ~r_spin_q;
   assign w_fb_rise   = feedback_i & ~r_fb_q;
   assign w_bank      = (int'(spin_bank_i) < NUM_BANK) ? spin_bank_i : '0;
   assign w_spin_load = w_spin_rise && !w_any_wwl && !w_busy;
   assign w_fb_spins  = r_spin_cache[w_fb_bank];

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_err_code = ERR_NONE;
      if (!w_onehot0)                       w_err_code = ERR_WWL_ONEHOT;
      else if (write_spin_i && w_any_wwl)   w_err_code = ERR_WWL_SPIN;
      else if (w_spin_rise && w_busy)       w_err_code = ERR_SPIN_BUSY;
   end

   // Wordline is one-hot when a read is accepted, so an OR-mux selects the row.
   always_comb begin
      w_rd_data = '0;
      for (int r = 0; r < WWL_WIDTH; r++) begin
         if (wwl_i[r]) w_rd_data = w_rd_data | r_data[r];
      end
   end

   // NOTE: the weight array and spin cache are reset explicitly because the
   // model's contract is an all-zero macro after reset, not unknown contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wwl_q    <= '0;
         r_spin_q   <= 1'b0;
         r_fb_q     <= 1'b0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         for (int r = 0; r < WWL_WIDTH; r++) r_data[r] <= '0;
         for (int b = 0; b < NUM_BANK; b++) r_spin_cache[b] <= '0;
      end else begin
         r_wwl_q  <= wwl_i;
         r_spin_q <= write_spin_i;
         r_fb_q   <= feedback_i;

         if (w_onehot0 && !wbl_floating_i) begin
            for (int r = 0; r < WWL_WIDTH; r++) begin
               if (wwl_i[r] && !r_wwl_q[r]) r_data[r] <= wbl_i;
            end
         end

         if (w_onehot0 && wbl_floating_i && w_any_wwl) begin
            r_rd_data  <= w_rd_data;
            r_rd_valid <= 1'b1;
         end else begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end

         if (w_spin_load) begin
            for (int i = 0; i < NUM_SPIN; i++) begin
               r_spin_cache[w_bank][i] <= wbl_i[BIT_DATA*i + SPIN_WBL_OFFSET];
            end
         end

         if (!r_err && (w_err_code != ERR_NONE)) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
         end
      end
   end

   galena_fb_timer #(
      .NUM_SPIN (NUM_SPIN),
      .CNT_W    (CNT_W),
      .BANK_W   (BANK_W)
   ) u_fb_timer (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_fb        (feedback_i),
      .i_fb_rise   (w_fb_rise),
      .i_settle    (settle_cycles_i),
      .i_bank      (w_bank),
      .i_spins     (w_fb_spins),
      .o_bank      (w_fb_bank),
      .o_busy      (w_busy),
      .o_bct       (bct_read_o),
      .o_bct_valid (bct_valid_o)
   );

   assign wbl_read_o       = r_rd_data;
   assign wblb_read_o      = ~r_rd_data;
   assign wbl_read_valid_o = r_rd_valid;
   assign err_o            = r_err;
   assign err_code_o       = r_err_code;

endmodule
